// File: rtl/acq_stream_unpacker_pkg.sv
// Shared definitions for the acquisition stream unpacker: word tags, parser
// state encoding, header field positions and the sample-pair packing helper.
package acq_stream_unpacker_pkg;

    localparam logic [3:0] TAG_FILL_HDR = 4'h1;
    localparam logic [3:0] TAG_WFM_HDR  = 4'h2;
    localparam logic [3:0] TAG_DATA     = 4'h4;
    localparam logic [3:0] TAG_TRAILER  = 4'h8;

    localparam int PAYLOAD_W      = 128;
    localparam int WORD_W         = 132;
    localparam int SB_W           = 130;   // payload + sof + eof sideband
    localparam int PAIR_W         = 26;
    localparam int FILL_NUM_W     = 24;
    localparam int NUM_BURSTS_LSB = 0;
    localparam int NUM_BURSTS_W   = 14;
    localparam int WFM_NUM_LSB    = 14;
    localparam int WFM_NUM_W      = 23;

    // Error flag bit positions inside err_flags.
    localparam int ERR_TAG  = 0;
    localparam int ERR_LEN  = 1;
    localparam int ERR_CSUM = 2;
    localparam int ERR_OVFL = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WFM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Lane idx of a 128b data word -> {smp1, ovr1, smp0, ovr0}.
    // Each 16-bit slot holds a 12-bit sample at [11:0] and its overrange flag at [12].
    function automatic logic [PAIR_W-1:0] pack_pair(input logic [PAYLOAD_W-1:0] word,
                                                    input logic [1:0]           idx);
        logic [6:0] base;
        base = {idx, 5'd0};
        return {word[base + 7'd16 +: 12], word[base + 7'd28],
                word[base +: 12],         word[base + 7'd12]};
    endfunction

endpackage

// File: rtl/acq_word_fifo.sv
// Synchronous data-word FIFO with a registered read port. The head word is
// re-registered every cycle so the serialiser sees it one cycle after the
// FIFO becomes non-empty; a pop advances the register to the following word.
module acq_word_fifo
    import acq_stream_unpacker_pkg::*;
#(
    parameter int AW = 4,
    parameter int W  = SB_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_word,
    input  logic         pop,
    output logic [W-1:0] rd_word,
    output logic         rd_valid,
    output logic         drop
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_r [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_ptr_inc_s;
    logic [AW:0]   count_r;
    logic [AW:0]   count_after_pop_s;
    logic          accept_s;
    logic [W-1:0]  rd_word_r;
    logic          rd_valid_r;

    // Push acceptance: a pop in the same cycle frees a slot even when full.
    always_comb begin
        accept_s          = push && ((count_r != DEPTH) || pop);
        drop              = push && !accept_s;
        rd_ptr_inc_s      = rd_ptr_r + AW'(1);
        count_after_pop_s = count_r - {{AW{1'b0}}, pop};
    end

    // Storage array write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= push_word;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            rd_word_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r    <= count_after_pop_s + {{AW{1'b0}}, accept_s};
            // Only entries written in earlier cycles are ever shown valid.
            rd_word_r  <= pop ? mem_r[rd_ptr_inc_s] : mem_r[rd_ptr_r];
            rd_valid_r <= (count_after_pop_s != '0);
        end
    end

    assign rd_word  = rd_word_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: rtl/acq_stream_unpacker.sv
// Receive-side decoder for the 132-bit tagged acquisition stream. Parses fill,
// waveform, data and trailer words, checks framing/length/checksum and
// re-serialises data words into 26-bit packed sample pairs.
module acq_stream_unpacker
    import acq_stream_unpacker_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int CSUM_W  = 128
)(
    input  logic                  adc_clk,
    input  logic                  reset_clk_adc_n,
    input  logic [WORD_W-1:0]     in_dat,
    input  logic                  in_valid,
    output logic [PAIR_W-1:0]     out_dat,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    input  logic                  out_ready,
    output logic [FILL_NUM_W-1:0] fill_num,
    output logic [WFM_NUM_W-1:0]  wfm_num,
    output logic                  fill_done,
    output logic                  csum_ok,
    output logic [3:0]            err_flags
);

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [3:0]              tag_s;
    logic [PAYLOAD_W-1:0]    payload_s;
    logic [NUM_BURSTS_W-1:0] nb_s;

    logic                    start_fill_s;
    logic                    load_wfm_s;
    logic                    data_s;
    logic                    take_trl_s;
    logic                    tag_err_s;
    logic                    len_err_s;
    logic                    done_s;
    logic                    csum_match_s;

    logic [FILL_NUM_W-1:0]   fill_num_r;
    logic [WFM_NUM_W-1:0]    wfm_num_r;
    logic                    fill_done_r;
    logic                    csum_ok_r;
    logic [3:0]              err_flags_r;
    logic [CSUM_W-1:0]       csum_r;
    logic [CSUM_W-1:0]       trailer_r;
    logic [NUM_BURSTS_W-1:0] burst_cnt_r;
    logic                    first_r;

    logic [SB_W-1:0]         fifo_rd_word_s;
    logic                    fifo_rd_valid_s;
    logic                    fifo_drop_s;
    logic                    pop_s;
    logic                    consume_s;
    logic [1:0]              pair_idx_r;

    assign tag_s     = in_dat[WORD_W-1:PAYLOAD_W];
    assign payload_s = in_dat[PAYLOAD_W-1:0];
    assign nb_s      = payload_s[NUM_BURSTS_LSB +: NUM_BURSTS_W];

    // Parser state register.
    always_ff @(posedge adc_clk) begin
        if (!reset_clk_adc_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Parser next state; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (in_valid) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    state_nxt_s = (tag_s == TAG_FILL_HDR) ? ST_FILL : ST_IDLE;
                end
                ST_FILL: begin
                    case (tag_s)
                        TAG_WFM_HDR: state_nxt_s = (nb_s == 14'd0) ? ST_FILL : ST_WFM;
                        TAG_TRAILER: state_nxt_s = ST_DONE;
                        default:     state_nxt_s = ST_FILL;
                    endcase
                end
                ST_WFM: begin
                    case (tag_s)
                        TAG_DATA:     state_nxt_s = (burst_cnt_r == 14'd1) ? ST_FILL : ST_WFM;
                        TAG_WFM_HDR:  state_nxt_s = (nb_s == 14'd0) ? ST_FILL : ST_WFM;
                        TAG_TRAILER:  state_nxt_s = ST_DONE;
                        TAG_FILL_HDR: state_nxt_s = ST_FILL;
                        default:      state_nxt_s = ST_WFM;
                    endcase
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else if (state_r == ST_DONE) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Parser output strobes driving the datapath registers.
    always_comb begin
        start_fill_s = 1'b0;
        load_wfm_s   = 1'b0;
        data_s       = 1'b0;
        take_trl_s   = 1'b0;
        tag_err_s    = 1'b0;
        len_err_s    = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (tag_s == TAG_FILL_HDR) begin
                        start_fill_s = 1'b1;
                    end else begin
                        tag_err_s = 1'b1;
                    end
                end
                ST_FILL: begin
                    case (tag_s)
                        TAG_WFM_HDR: begin
                            load_wfm_s = 1'b1;
                            len_err_s  = (nb_s == 14'd0);
                        end
                        TAG_TRAILER: take_trl_s = 1'b1;
                        default:     tag_err_s  = 1'b1;
                    endcase
                end
                ST_WFM: begin
                    case (tag_s)
                        TAG_DATA: data_s = 1'b1;
                        TAG_WFM_HDR: begin
                            load_wfm_s = 1'b1;
                            len_err_s  = 1'b1;
                        end
                        TAG_TRAILER: begin
                            take_trl_s = 1'b1;
                            len_err_s  = 1'b1;
                        end
                        TAG_FILL_HDR: begin
                            start_fill_s = 1'b1;
                            tag_err_s    = 1'b1;
                        end
                        default: tag_err_s = 1'b1;
                    endcase
                end
                default: tag_err_s = 1'b0;
            endcase
        end else begin
            tag_err_s = 1'b0;
        end
    end

    assign done_s       = (state_r == ST_DONE);
    assign csum_match_s = (csum_r == trailer_r);

    // Fill/waveform bookkeeping, running checksum and sticky status.
    always_ff @(posedge adc_clk) begin
        if (!reset_clk_adc_n) begin
            fill_num_r  <= '0;
            wfm_num_r   <= '0;
            fill_done_r <= 1'b0;
            csum_ok_r   <= 1'b0;
            err_flags_r <= 4'b0000;
            csum_r      <= '0;
            trailer_r   <= '0;
            burst_cnt_r <= '0;
            first_r     <= 1'b0;
        end else begin
            fill_done_r <= done_s;
            if (start_fill_s) begin
                // A new fill header wipes status; a tag error on it is re-flagged.
                fill_num_r  <= payload_s[FILL_NUM_W-1:0];
                csum_r      <= payload_s[CSUM_W-1:0];
                csum_ok_r   <= 1'b0;
                err_flags_r <= {3'b000, tag_err_s};
            end else begin
                if (load_wfm_s || data_s) begin
                    csum_r <= csum_r ^ payload_s[CSUM_W-1:0];
                end
                if (done_s) begin
                    csum_ok_r <= csum_match_s;
                end
                err_flags_r[ERR_TAG]  <= err_flags_r[ERR_TAG]  | tag_err_s;
                err_flags_r[ERR_LEN]  <= err_flags_r[ERR_LEN]  | len_err_s;
                err_flags_r[ERR_CSUM] <= err_flags_r[ERR_CSUM] | (done_s && !csum_match_s);
                err_flags_r[ERR_OVFL] <= err_flags_r[ERR_OVFL] | fifo_drop_s;
            end
            if (load_wfm_s) begin
                wfm_num_r   <= payload_s[WFM_NUM_LSB +: WFM_NUM_W];
                burst_cnt_r <= nb_s;
                first_r     <= 1'b1;
            end else if (data_s) begin
                // Dropped words still count against the burst length.
                burst_cnt_r <= burst_cnt_r - 14'd1;
                first_r     <= 1'b0;
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
            if (take_trl_s) begin
                trailer_r <= payload_s[CSUM_W-1:0];
            end
        end
    end

    // A word is released only after its fourth pair has been accepted.
    assign consume_s = fifo_rd_valid_s && out_ready;
    assign pop_s     = consume_s && (pair_idx_r == 2'd3);

    acq_word_fifo #(
        .AW (FIFO_AW),
        .W  (SB_W)
    ) u_fifo (
        .clk       (adc_clk),
        .rst_n     (reset_clk_adc_n),
        .push      (data_s),
        .push_word ({(burst_cnt_r == 14'd1), first_r, payload_s}),
        .pop       (pop_s),
        .rd_word   (fifo_rd_word_s),
        .rd_valid  (fifo_rd_valid_s),
        .drop      (fifo_drop_s)
    );

    // Pair index within the head word; holds while downstream stalls.
    always_ff @(posedge adc_clk) begin
        if (!reset_clk_adc_n) begin
            pair_idx_r <= 2'd0;
        end else if (consume_s) begin
            pair_idx_r <= pair_idx_r + 2'd1;
        end else begin
            pair_idx_r <= pair_idx_r;
        end
    end

    assign out_dat   = pack_pair(fifo_rd_word_s[PAYLOAD_W-1:0], pair_idx_r);
    assign out_valid = fifo_rd_valid_s;
    assign out_sof   = fifo_rd_valid_s && fifo_rd_word_s[PAYLOAD_W]     && (pair_idx_r == 2'd0);
    assign out_eof   = fifo_rd_valid_s && fifo_rd_word_s[PAYLOAD_W + 1] && (pair_idx_r == 2'd3);

    assign fill_num  = fill_num_r;
    assign wfm_num   = wfm_num_r;
    assign fill_done = fill_done_r;
    assign csum_ok   = csum_ok_r;
    assign err_flags = err_flags_r;

endmodule

// File: tb/tb_acq_stream_unpacker.sv
// Self-checking bench for acq_stream_unpacker: a table of fill scenarios plus
// hand-written overflow, bad-tag and mid-fill reset sequences. Expected pairs
// go into a scoreboard queue when data words are driven.
module tb_acq_stream_unpacker;
    import acq_stream_unpacker_pkg::*;

    logic         adc_clk;
    logic         reset_clk_adc_n;
    logic [131:0] in_dat;
    logic         in_valid;
    logic [25:0]  out_dat;
    logic         out_valid;
    logic         out_sof;
    logic         out_eof;
    logic         out_ready;
    logic [23:0]  fill_num;
    logic [22:0]  wfm_num;
    logic         fill_done;
    logic         csum_ok;
    logic [3:0]   err_flags;

    acq_stream_unpacker #(.FIFO_AW(4), .CSUM_W(128)) dut (
        .adc_clk         (adc_clk),
        .reset_clk_adc_n (reset_clk_adc_n),
        .in_dat          (in_dat),
        .in_valid        (in_valid),
        .out_dat         (out_dat),
        .out_valid       (out_valid),
        .out_sof         (out_sof),
        .out_eof         (out_eof),
        .out_ready       (out_ready),
        .fill_num        (fill_num),
        .wfm_num         (wfm_num),
        .fill_done       (fill_done),
        .csum_ok         (csum_ok),
        .err_flags       (err_flags)
    );

    typedef struct {
        logic [25:0] dat;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct {
        logic [23:0]  fill;
        logic [22:0]  wfm;
        logic [13:0]  bursts;
        int           ndata;
        logic [127:0] csum_delta;
        int           rdy_mode;
        logic [3:0]   exp_err;
        logic         exp_ok;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   pair_cnt = 0;
    int   rdy_mode = 0;
    vec_t vecs[5];

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge adc_clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard compare, fill_done pulse count, stall hold.
    initial begin
        logic        prev_stall;
        logic [25:0] prev_dat;
        exp_t        e;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge adc_clk);
            if (reset_clk_adc_n && prev_stall) begin
                chk("stall_hold", {out_valid, out_dat}, {1'b1, prev_dat});
            end
            if (reset_clk_adc_n && fill_done) done_cnt++;
            if (reset_clk_adc_n && out_valid && out_ready) begin
                pair_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_pair", 128'(out_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("pair_dat", 128'(out_dat), 128'(e.dat));
                    chk("pair_sofeof", {out_sof, out_eof}, {e.sof, e.eof});
                end
            end
            prev_stall = reset_clk_adc_n && out_valid && !out_ready;
            prev_dat   = out_dat;
        end
    end

    task automatic send_word(input logic [3:0] tag, input logic [127:0] pl);
        @(posedge adc_clk);
        #1;
        in_dat   = {tag, pl};
        in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Expected pairs of one data word, derived from the lane layout.
    task automatic push_exp(input logic [127:0] w, input logic sof, input logic eof);
        exp_t        e;
        logic [31:0] lane;
        for (int p = 0; p < 4; p++) begin
            lane  = w[32*p +: 32];
            e.dat = {lane[27:16], lane[28], lane[11:0], lane[12]};
            e.sof = sof && (p == 0);
            e.eof = eof && (p == 3);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 3000 && sb.size() != 0; c++) @(posedge adc_clk);
        chk({"drain_", nm}, 128'(sb.size()), 128'(0));
    endtask

    task automatic run_fill(input vec_t v, input string nm);
        logic [127:0] cs;
        logic [127:0] pl;
        done_cnt = 0;
        rdy_mode = v.rdy_mode;
        pl = {104'd0, v.fill};
        send_word(TAG_FILL_HDR, pl);
        cs = pl;
        pl = {91'd0, v.wfm, v.bursts};
        send_word(TAG_WFM_HDR, pl);
        cs = cs ^ pl;
        for (int k = 0; k < v.ndata; k++) begin
            pl = {$urandom, $urandom, $urandom, $urandom};
            send_word(TAG_DATA, pl);
            cs = cs ^ pl;
            push_exp(pl, k == 0, k == int'(v.bursts) - 1);
        end
        send_word(TAG_TRAILER, cs ^ v.csum_delta);
        idle(1);
        drain(nm);
        idle(3);
        @(negedge adc_clk);
        chk({nm, "_fill_done"}, 128'(done_cnt), 128'(1));
        chk({nm, "_csum_ok"},   128'(csum_ok),  128'(v.exp_ok));
        chk({nm, "_err"},       128'(err_flags), 128'(v.exp_err));
        chk({nm, "_fill_num"},  128'(fill_num), 128'(v.fill));
        chk({nm, "_wfm_num"},   128'(wfm_num),  128'(v.wfm));
        rdy_mode = 0;
    endtask

    initial begin
        logic [127:0] cs;
        logic [127:0] pl;
        vecs[0] = '{24'h00ABCD, 23'd5,       14'd2, 2, 128'd0, 0, 4'b0000, 1'b1};
        vecs[1] = '{24'h00ABCD, 23'd5,       14'd2, 2, 128'd1, 0, 4'b0100, 1'b0};
        vecs[2] = '{24'h123456, 23'd7,       14'd3, 2, 128'd0, 0, 4'b0010, 1'b1};
        vecs[3] = '{24'hFFFFFF, 23'h7FFFFF,  14'd1, 1, 128'd0, 1, 4'b0000, 1'b1};
        vecs[4] = '{24'h000001, 23'd3,       14'd4, 4, 128'd0, 1, 4'b0000, 1'b1};

        reset_clk_adc_n = 1'b0;
        in_valid        = 1'b0;
        in_dat          = '0;
        repeat (3) @(posedge adc_clk);
        @(negedge adc_clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_err",       128'(err_flags), 128'(0));
        chk("rst_fill_num",  128'(fill_num),  128'(0));
        chk("rst_csum_ok",   128'(csum_ok),   128'(0));
        chk("rst_fill_done", 128'(fill_done), 128'(0));
        @(posedge adc_clk);
        #1;
        reset_clk_adc_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_fill(vecs[i], $sformatf("vec%0d", i));
        end

        // Overflow: 20 words into a stalled 16-deep buffer.
        rdy_mode = 2;
        done_cnt = 0;
        pl = {104'd0, 24'h000777};
        send_word(TAG_FILL_HDR, pl);
        cs = pl;
        pl = {91'd0, 23'd9, 14'd20};
        send_word(TAG_WFM_HDR, pl);
        cs = cs ^ pl;
        for (int k = 0; k < 20; k++) begin
            pl = {$urandom, $urandom, $urandom, $urandom};
            send_word(TAG_DATA, pl);
            cs = cs ^ pl;
            if (k < 16) push_exp(pl, k == 0, 1'b0);
        end
        send_word(TAG_TRAILER, cs);
        idle(1);
        repeat (75) @(posedge adc_clk);
        @(negedge adc_clk);
        chk("ovfl_err",      128'(err_flags), 128'(4'b1000));
        chk("ovfl_csum_ok",  128'(csum_ok),   128'(1));
        chk("ovfl_done",     128'(done_cnt),  128'(1));
        chk("ovfl_held",     128'(sb.size()), 128'(64));
        pair_cnt = 0;
        rdy_mode = 0;
        drain("ovfl");
        repeat (10) @(posedge adc_clk);
        @(negedge adc_clk);
        chk("ovfl_pairs",    128'(pair_cnt),  128'(64));

        // Bad tag in IDLE, then a clean fill clears it.
        send_word(4'h3, 128'h0);
        idle(2);
        @(negedge adc_clk);
        chk("badtag_err", 128'(err_flags), 128'(4'b1001));
        run_fill(vecs[0], "after_badtag");

        // Reset in the middle of a waveform.
        rdy_mode = 0;
        send_word(TAG_FILL_HDR, {104'd0, 24'h000042});
        send_word(TAG_WFM_HDR,  {91'd0, 23'd2, 14'd4});
        for (int k = 0; k < 2; k++) begin
            pl = {$urandom, $urandom, $urandom, $urandom};
            send_word(TAG_DATA, pl);
            push_exp(pl, k == 0, 1'b0);
        end
        @(posedge adc_clk);
        #1;
        in_valid        = 1'b0;
        reset_clk_adc_n = 1'b0;
        @(posedge adc_clk);
        #1;
        reset_clk_adc_n = 1'b1;
        sb.delete();
        @(negedge adc_clk);
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_fill_num",  128'(fill_num),  128'(0));
        chk("midrst_err",       128'(err_flags), 128'(0));
        repeat (5) @(negedge adc_clk);
        chk("midrst_empty",     128'(out_valid), 128'(0));
        run_fill(vecs[4], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
